// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store bus master.
package lsu_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] off;
    } track_entry_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] wstrb_gen(input logic is_store, input logic [2:0] funct3,
                                             input logic [1:0] off);
        logic [3:0] w_strb;
        w_strb = 4'b0000;
        if (is_store) begin
            case (funct3)
                F3_B:    w_strb = 4'b0001 << off;
                F3_H:    w_strb = 4'b0011 << off;
                F3_W:    w_strb = 4'b1111;
                default: w_strb = 4'b0000;
            endcase
        end
        return w_strb;
    endfunction

endpackage

// File: rtl/lsu_track_fifo.sv
// In-order tracker of issued bus transactions: circular buffer with occupancy count.
module lsu_track_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  track_entry_t push_data,
    input  logic         pop,
    output track_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    track_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (r_count <= CW'(DEPTH)) else $error("lsu_track_fifo: count exceeds depth");
        end
    end

endmodule

// File: rtl/lsu_bus_master.sv
// CPU-side initiator for the req/addr_ok/data_ok data port: decode, bus drive, in-order responses.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 2
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cpu_req_valid,
    output logic            cpu_req_ready,
    input  logic [3:0]      cpu_req_op,
    input  logic [AW-1:0]   cpu_req_addr,
    input  logic [DW-1:0]   cpu_req_wdata,
    output logic            cpu_resp_valid,
    output logic [DW-1:0]   cpu_resp_rdata,
    output logic            cpu_resp_err,
    output logic            data_req,
    output logic            data_write,
    output logic [DW/8-1:0] data_wstrb,
    output logic [AW-1:0]   data_addr,
    output logic [DW-1:0]   data_wdata,
    input  logic            data_addr_ok,
    input  logic            data_data_ok,
    input  logic [DW-1:0]   data_rdata
);

    generate
        if (DW != 32) begin : g_dw_check
            $error("lsu_bus_master: only DW=32 is supported");
        end
        if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_depth_check
            $error("lsu_bus_master: MAX_OUTSTANDING must be 1..4");
        end
    endgenerate

    logic         w_is_store;
    logic [2:0]   w_funct3;
    logic [1:0]   w_off;
    logic         w_bad;
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic         w_err_accept;
    track_entry_t w_push_entry;
    track_entry_t w_head;

    logic          r_err_pend;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic [DW-1:0] r_resp_rdata;

    function automatic logic [31:0] load_extend(input track_entry_t e, input logic [31:0] word);
        logic [7:0]  w_byte;
        logic [15:0] w_half;
        w_byte = word[{e.off, 3'b000} +: 8];
        w_half = e.off[1] ? word[31:16] : word[15:0];
        if (e.is_store) return 32'h0;
        case (e.funct3)
            F3_B:    return {{24{w_byte[7]}}, w_byte};
            F3_BU:   return {24'h0, w_byte};
            F3_H:    return {{16{w_half[15]}}, w_half};
            F3_HU:   return {16'h0, w_half};
            F3_W:    return word;
            default: return 32'h0;
        endcase
    endfunction

    assign w_is_store = cpu_req_op[3];
    assign w_funct3   = cpu_req_op[2:0];
    assign w_off      = cpu_req_addr[1:0];

    always_comb begin
        w_bad = ~op_legal(cpu_req_op);
        if (w_funct3[1:0] == 2'b01 && w_off[0])     w_bad = 1'b1;
        if (w_funct3[1:0] == 2'b10 && w_off != 2'b00) w_bad = 1'b1;
    end

    // Errors wait for an empty tracker so they never overtake earlier bus responses.
    assign data_req      = rst_n & cpu_req_valid & ~w_bad & ~w_full;
    assign w_push        = data_req & data_addr_ok;
    assign w_err_accept  = rst_n & cpu_req_valid & w_bad & w_empty & ~r_err_pend;
    assign cpu_req_ready = w_push | w_err_accept;
    assign w_pop         = data_data_ok & ~w_empty;

    assign data_write = w_is_store;
    assign data_addr  = {cpu_req_addr[AW-1:2], 2'b00};
    assign data_wstrb = wstrb_gen(w_is_store, w_funct3, w_off);

    always_comb begin
        case (w_funct3[1:0])
            2'b00:   data_wdata = {4{cpu_req_wdata[7:0]}};
            2'b01:   data_wdata = {2{cpu_req_wdata[15:0]}};
            default: data_wdata = cpu_req_wdata;
        endcase
    end

    assign w_push_entry = '{is_store: w_is_store, funct3: w_funct3, off: w_off};

    lsu_track_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_track (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pend   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_err_pend   <= w_err_accept;
            r_resp_valid <= w_pop | w_err_accept;
            r_resp_err   <= w_err_accept;
            r_resp_rdata <= w_pop ? load_extend(w_head, data_rdata) : '0;
        end
    end

    assign cpu_resp_valid = r_resp_valid;
    assign cpu_resp_err   = r_resp_err;
    assign cpu_resp_rdata = r_resp_rdata;

    always_ff @(posedge clk) begin
        if (rst_n && data_data_ok && w_empty) begin
            assert (!w_pop) else $error("lsu_bus_master: data_ok popped an empty tracker");
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed-vector bench for lsu_bus_master with hand-computed expectations.
module tb_lsu_bus_master;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic [3:0]  cpu_req_op = 4'h0;
    logic [31:0] cpu_req_addr = 32'h0;
    logic [31:0] cpu_req_wdata = 32'h0;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        cpu_resp_err;
    logic        data_req;
    logic        data_write;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'h0;

    int total = 0;
    int bad   = 0;

    lsu_bus_master #(.AW(32), .DW(32), .MAX_OUTSTANDING(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_op     (cpu_req_op),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .cpu_resp_err   (cpu_resp_err),
        .data_req       (data_req),
        .data_write     (data_write),
        .data_wstrb     (data_wstrb),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpu_req_valid && cpu_req_ready)
            $display("req  op=%h addr=%08h wdata=%08h", cpu_req_op, cpu_req_addr, cpu_req_wdata);
        if (cpu_resp_valid)
            $display("resp rdata=%08h err=%0b", cpu_resp_rdata, cpu_resp_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] wd);
        cpu_req_valid = v;
        cpu_req_op    = op;
        cpu_req_addr  = a;
        cpu_req_wdata = wd;
    endtask

    task automatic drive_bus(input logic aok, input logic dok, input logic [31:0] rd);
        data_addr_ok = aok;
        data_data_ok = dok;
        data_rdata   = rd;
    endtask

    task automatic test_reset();
        drive_req(1'b1, OP_LW, 32'h0, 32'h0);
        drive_bus(1'b1, 1'b0, 32'h0);
        #2;
        total++; if (data_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", data_req); end
        total++; if (cpu_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", cpu_req_ready); end
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", cpu_resp_valid); end
        total++; if (cpu_resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %08h want 0", cpu_resp_rdata); end
        total++; if (cpu_resp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", cpu_resp_err); end
        tick();
        tick();
        drive_req(1'b0, OP_LW, 32'h0, 32'h0);
        drive_bus(1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lb();
        drive_req(1'b1, OP_LB, 32'h1003, 32'h0);
        drive_bus(1'b1, 1'b0, 32'h0);
        #1;
        total++; if (data_req !== 1'b1) begin bad++; $display("FAIL lb_req: got %b want 1", data_req); end
        total++; if (data_addr !== 32'h1000) begin bad++; $display("FAIL lb_addr: got %08h want 00001000", data_addr); end
        total++; if (data_wstrb !== 4'b0000) begin bad++; $display("FAIL lb_wstrb: got %b want 0000", data_wstrb); end
        total++; if (data_write !== 1'b0) begin bad++; $display("FAIL lb_write: got %b want 0", data_write); end
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL lb_ready: got %b want 1", cpu_req_ready); end
        tick();
        drive_req(1'b0, OP_LB, 32'h0, 32'h0);
        drive_bus(1'b0, 1'b1, 32'h80FF_1234);
        #1;
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL lb_early: got %b want 0", cpu_resp_valid); end
        tick();
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        total++; if (cpu_resp_valid !== 1'b1) begin bad++; $display("FAIL lb_rvalid: got %b want 1", cpu_resp_valid); end
        total++; if (cpu_resp_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata: got %08h want ffffff80", cpu_resp_rdata); end
        total++; if (cpu_resp_err !== 1'b0) begin bad++; $display("FAIL lb_err: got %b want 0", cpu_resp_err); end
        tick();
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL lb_pulse: got %b want 0", cpu_resp_valid); end
    endtask

    task automatic test_sh();
        drive_req(1'b1, OP_SH, 32'h2002, 32'h0000_ABCD);
        drive_bus(1'b1, 1'b0, 32'h0);
        #1;
        total++; if (data_write !== 1'b1) begin bad++; $display("FAIL sh_write: got %b want 1", data_write); end
        total++; if (data_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_wstrb: got %b want 1100", data_wstrb); end
        total++; if (data_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata: got %08h want abcdabcd", data_wdata); end
        total++; if (data_addr !== 32'h2000) begin bad++; $display("FAIL sh_addr: got %08h want 00002000", data_addr); end
        tick();
        drive_req(1'b0, OP_SH, 32'h0, 32'h0);
        drive_bus(1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        total++; if (cpu_resp_valid !== 1'b1) begin bad++; $display("FAIL sh_rvalid: got %b want 1", cpu_resp_valid); end
        total++; if (cpu_resp_rdata !== 32'h0) begin bad++; $display("FAIL sh_rdata: got %08h want 0", cpu_resp_rdata); end
        total++; if (cpu_resp_err !== 1'b0) begin bad++; $display("FAIL sh_err: got %b want 0", cpu_resp_err); end
        tick();
    endtask

    task automatic test_misaligned();
        drive_req(1'b1, OP_LW, 32'h100, 32'h0);
        drive_bus(1'b1, 1'b0, 32'h0);
        tick();
        drive_req(1'b1, OP_LW, 32'h0001, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (data_req !== 1'b0) begin bad++; $display("FAIL mis_req%0d: got %b want 0", i, data_req); end
            total++; if (cpu_req_ready !== 1'b0) begin bad++; $display("FAIL mis_stall%0d: got %b want 0", i, cpu_req_ready); end
            tick();
        end
        drive_bus(1'b1, 1'b1, 32'h1122_3344);
        #1;
        total++; if (cpu_req_ready !== 1'b0) begin bad++; $display("FAIL mis_nobypass: got %b want 0", cpu_req_ready); end
        tick();
        drive_bus(1'b1, 1'b0, 32'h0);
        #1;
        total++; if (cpu_resp_rdata !== 32'h1122_3344 || cpu_resp_valid !== 1'b1) begin bad++; $display("FAIL mis_prior: got v=%b %08h want v=1 11223344", cpu_resp_valid, cpu_resp_rdata); end
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL mis_ready: got %b want 1", cpu_req_ready); end
        total++; if (data_req !== 1'b0) begin bad++; $display("FAIL mis_noreq: got %b want 0", data_req); end
        tick();
        drive_req(1'b0, OP_LW, 32'h0, 32'h0);
        #1;
        total++; if (cpu_resp_valid !== 1'b1) begin bad++; $display("FAIL mis_rvalid: got %b want 1", cpu_resp_valid); end
        total++; if (cpu_resp_err !== 1'b1) begin bad++; $display("FAIL mis_err: got %b want 1", cpu_resp_err); end
        total++; if (cpu_resp_rdata !== 32'h0) begin bad++; $display("FAIL mis_rdata: got %08h want 0", cpu_resp_rdata); end
        tick();
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL mis_pulse: got %b want 0", cpu_resp_valid); end
    endtask

    task automatic test_stall();
        drive_req(1'b1, OP_LHU, 32'h10, 32'h0);
        drive_bus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (data_req !== 1'b1) begin bad++; $display("FAIL stall_req%0d: got %b want 1", i, data_req); end
            total++; if (data_addr !== 32'h10 || data_wstrb !== 4'b0000 || data_write !== 1'b0) begin bad++; $display("FAIL stall_bus%0d: got %08h/%b/%b want 00000010/0000/0", i, data_addr, data_wstrb, data_write); end
            total++; if (cpu_req_ready !== 1'b0) begin bad++; $display("FAIL stall_ready%0d: got %b want 0", i, cpu_req_ready); end
            tick();
        end
        drive_bus(1'b1, 1'b0, 32'h0);
        #1;
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL stall_accept: got %b want 1", cpu_req_ready); end
        tick();
        drive_req(1'b0, OP_LHU, 32'h0, 32'h0);
        drive_bus(1'b0, 1'b1, 32'h1234_5678);
        tick();
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        total++; if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h0000_5678) begin bad++; $display("FAIL stall_rdata: got v=%b %08h want v=1 00005678", cpu_resp_valid, cpu_resp_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_req(1'b1, OP_LW, 32'h0, 32'h0);
        drive_bus(1'b1, 1'b0, 32'h0);
        #1;
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_acc0: got %b want 1", cpu_req_ready); end
        tick();
        drive_req(1'b1, OP_LW, 32'h4, 32'h0);
        #1;
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_acc1: got %b want 1", cpu_req_ready); end
        tick();
        drive_req(1'b1, OP_LW, 32'h8, 32'h0);
        drive_bus(1'b1, 1'b1, 32'hA0A0_0000);
        #1;
        total++; if (data_req !== 1'b0 || cpu_req_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: got req=%b rdy=%b want 0/0", data_req, cpu_req_ready); end
        tick();
        drive_bus(1'b1, 1'b0, 32'h0);
        #1;
        total++; if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'hA0A0_0000) begin bad++; $display("FAIL b2b_r0: got v=%b %08h want v=1 a0a00000", cpu_resp_valid, cpu_resp_rdata); end
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_acc2: got %b want 1", cpu_req_ready); end
        tick();
        drive_req(1'b1, OP_LW, 32'hC, 32'h0);
        drive_bus(1'b1, 1'b1, 32'hA1A1_0001);
        #1;
        total++; if (cpu_req_ready !== 1'b0) begin bad++; $display("FAIL b2b_full2: got %b want 0", cpu_req_ready); end
        tick();
        drive_bus(1'b1, 1'b1, 32'hA2A2_0002);
        #1;
        total++; if (cpu_resp_rdata !== 32'hA1A1_0001) begin bad++; $display("FAIL b2b_r1: got %08h want a1a10001", cpu_resp_rdata); end
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_pushpop: got %b want 1", cpu_req_ready); end
        tick();
        drive_req(1'b1, OP_LW, 32'h10, 32'h0);
        drive_bus(1'b1, 1'b0, 32'h0);
        #1;
        total++; if (cpu_resp_rdata !== 32'hA2A2_0002) begin bad++; $display("FAIL b2b_r2: got %08h want a2a20002", cpu_resp_rdata); end
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_acc4: got %b want 1", cpu_req_ready); end
        tick();
        drive_req(1'b1, OP_LW, 32'h14, 32'h0);
        #1;
        total++; if (cpu_req_ready !== 1'b0 || data_req !== 1'b0) begin bad++; $display("FAIL b2b_full3: got rdy=%b req=%b want 0/0", cpu_req_ready, data_req); end
        drive_req(1'b0, OP_LW, 32'h0, 32'h0);
        drive_bus(1'b0, 1'b1, 32'hA3A3_0003);
        tick();
        drive_bus(1'b0, 1'b1, 32'hA4A4_0004);
        #1;
        total++; if (cpu_resp_rdata !== 32'hA3A3_0003) begin bad++; $display("FAIL b2b_r3: got %08h want a3a30003", cpu_resp_rdata); end
        tick();
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        total++; if (cpu_resp_rdata !== 32'hA4A4_0004 || cpu_resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_r4: got v=%b %08h want v=1 a4a40004", cpu_resp_valid, cpu_resp_rdata); end
        tick();
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained: got %b want 0", cpu_resp_valid); end
    endtask

    task automatic test_reset_mid();
        drive_req(1'b1, OP_LW, 32'h20, 32'h0);
        drive_bus(1'b1, 1'b0, 32'h0);
        tick();
        drive_req(1'b1, OP_LW, 32'h24, 32'h0);
        tick();
        drive_req(1'b1, OP_LW, 32'h30, 32'h0);
        drive_bus(1'b1, 1'b1, 32'hCAFE_0000);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (cpu_resp_valid !== 1'b0 || data_req !== 1'b0) begin bad++; $display("FAIL rmid_async: got v=%b req=%b want 0/0", cpu_resp_valid, data_req); end
        tick();
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL rmid_held: got %b want 0", cpu_resp_valid); end
        drive_req(1'b0, OP_LW, 32'h0, 32'h0);
        drive_bus(1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        tick();
        drive_bus(1'b0, 1'b1, 32'hDEAD_DEAD);
        tick();
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale: got %b want 0", cpu_resp_valid); end
        drive_req(1'b1, OP_LW, 32'h30, 32'h0);
        drive_bus(1'b1, 1'b0, 32'h0);
        #1;
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL rmid_acc0: got %b want 1", cpu_req_ready); end
        tick();
        drive_req(1'b1, OP_LW, 32'h34, 32'h0);
        #1;
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL rmid_acc1: got %b want 1", cpu_req_ready); end
        tick();
        drive_req(1'b0, OP_LW, 32'h0, 32'h0);
        drive_bus(1'b0, 1'b1, 32'hB0B0_0000);
        tick();
        drive_bus(1'b0, 1'b1, 32'hB1B1_0001);
        #1;
        total++; if (cpu_resp_rdata !== 32'hB0B0_0000) begin bad++; $display("FAIL rmid_r0: got %08h want b0b00000", cpu_resp_rdata); end
        tick();
        drive_bus(1'b0, 1'b0, 32'h0);
        #1;
        total++; if (cpu_resp_rdata !== 32'hB1B1_0001 || cpu_resp_valid !== 1'b1) begin bad++; $display("FAIL rmid_r1: got v=%b %08h want v=1 b1b10001", cpu_resp_valid, cpu_resp_rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_misaligned();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Initiator for the core's req/addr_ok/data_ok memory port. It is the CPU-side end that drives the dual-port RAM's data port.
- Accepts load/store ops from the pipeline, forms word address, wstrb and lane-replicated wdata, and tracks up to MAX_OUTSTANDING in-order transactions.
- Returns aligned, sign/zero-extended load data or a store ack.
- Rejects misaligned or illegal ops with an error response; these never issue a bus request.

Parameters:
- AW, 32, address width
- DW, 32, data width; only 32 is supported, so generate a compile-time error otherwise
- MAX_OUTSTANDING, 2, max accepted-but-unacknowledged bus transactions (1..4)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req_valid  in  1  pipeline request valid
- cpu_req_ready  out  1  request accepted this cycle when valid&ready
- cpu_req_op  in  4  {is_store, funct3}; encodings in lsu_pkg
- cpu_req_addr  in  AW  byte address
- cpu_req_wdata  in  DW  store data, right-justified
- cpu_resp_valid  out  1  one-cycle response pulse; consumer always accepts
- cpu_resp_rdata  out  DW  extended load data; 0 for stores and errors
- cpu_resp_err  out  1  misaligned/illegal op
- data_req  out  1  bus request
- data_write  out  1  1=store
- data_wstrb  out  DW/8  byte enables; 0 for loads
- data_addr  out  AW  {cpu_req_addr[AW-1:2],2'b00}
- data_wdata  out  DW  lane-replicated store data
- data_addr_ok  in  1  responder accepts request this cycle
- data_data_ok  in  1  one per accepted request, reads and writes, in order, at least 1 cycle after acceptance
- data_rdata  in  DW  read word, valid with data_ok

Behaviour:
- Reset (async assert, sync release): cpu_resp_valid=0, cpu_resp_rdata=0, cpu_resp_err=0, tracker empty, count=0. Bus outputs are combinational, so data_req=0 during reset.
- Legal ops: LB 0000, LH 0001, LW 0010, LBU 0100, LHU 0101, SB 1000, SH 1001, SW 1010. Any other encoding is illegal.
- Bad = illegal op, or halfword op with addr[0]=1, or word op with addr[1:0]!=0.
- full = (count == MAX_OUTSTANDING). There is no same-cycle pop bypass, so full blocks acceptance even if data_ok arrives that cycle.
- Good request path:
  - data_req = cpu_req_valid & ~bad & ~full.
  - cpu_req_ready = data_req & data_addr_ok.
  - On accept, push {is_store, funct3, addr[1:0]} into the tracker.
- Bad request path:
  - cpu_req_ready = cpu_req_valid & (count==0) & ~err_pend. It stalls until the tracker drains so responses stay in order.
  - On accept, set err_pend. Next cycle: cpu_resp_valid=1, err=1, rdata=0; clear err_pend.
- wstrb: SB = 4'b0001<<off; SH = 4'b0011<<off; SW = 4'b1111; loads 0.
- wdata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW as-is.
- data_ok with tracker non-empty pops the head. Next cycle cpu_resp_valid=1, err=0. Latency is 1 cycle after data_ok.
- Response data uses the head's funct3/off:
  - LB/LBU: byte off, sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: half off[1], sign-extended (LH) or zero-extended (LHU).
  - LW: full word.
  - Stores: rdata=0.
- Simultaneous push and pop: count unchanged, both take effect.
- data_ok with an empty tracker is ignored; covered by a simulation assertion.
- count is never > MAX_OUTSTANDING; covered by an assertion.
- Bus outputs must hold stable while data_req=1 & ~data_addr_ok. The pipeline holds cpu_req_* until ready.
- Reset mid-operation flushes the tracker and err_pend. Responses for flushed transactions are never produced.

Decomposition:
- lsu_pkg: op encodings (OP_LB..OP_SW), funct3 constants, tracker entry struct {is_store, funct3[2:0], off[1:0]}, function for wstrb generation.
- Sub-module lsu_track_fifo: depth MAX_OUTSTANDING, circular pointers plus count, push/pop/full/empty, head output, async active-low reset.
- Parent module holds decode, the bus drive, err_pend and the response extension register.

Test Plan:
- LB at 0x1003, RAM word 0x80FF_1234 at 0x1000, addr_ok=1, data_ok 1 cycle later -> data_addr=0x1000, wstrb=0; resp 1 cycle after data_ok with rdata=0xFFFF_FF80, err=0.
- SH wdata=0x0000_ABCD at 0x2002 -> data_write=1, wstrb=4'b1100, data_wdata=0xABCD_ABCD; resp rdata=0, err=0.
- LW at 0x0001 with 1 outstanding load -> ready stays 0 until the outstanding resp, then resp err=1 one cycle after accept, data_req never asserted for it.
- addr_ok held 0 for 3 cycles on LHU 0x10 -> data_req and bus fields stable 3 cycles, ready=0; accept on cycle 4; data_ok returning 0x1234_5678 gives rdata=0x0000_5678.
- Back-to-back LW 0x0, LW 0x4, LW 0x8 with data_ok withheld -> first two accepted, third waits for full to clear; data_ok in the same cycle as a push keeps count=2; responses arrive in order.
- rst_n pulsed low with 2 outstanding -> resp_valid=0 and count=0 immediately; stale data_ok after release produces no response.
